// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
//
// Holds the FSM state enum, opcode and funct field values, the ALUOp enum,
// ALUControl codes and the ALUSrcB / PCSrc select codes used by the
// datapath. ALUOP_ADD is encoded as zero so that states which leave ALUOp
// unassigned naturally drive an add.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp/Funct to ALUControl decoder
//
// Ports:
//   ALUOp      in  operation class chosen by the control FSM
//   Funct      in  instruction funct field
//   ALUControl out 3-bit ALU operation code
//   FunctValid out Funct is one of the supported R-type functions
//                  (independent of ALUOp; DECODE uses it to drop bad R-types)
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t     ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       FunctValid
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl = ALU_ADD;
        FunctValid = 1'b1;
        case (Funct)
            FUNCT_ADD: funct_ctrl = ALU_ADD;
            FUNCT_SUB: funct_ctrl = ALU_SUB;
            FUNCT_AND: funct_ctrl = ALU_AND;
            FUNCT_OR:  funct_ctrl = ALU_OR;
            FUNCT_SLT: funct_ctrl = ALU_SLT;
            default: begin
                funct_ctrl = ALU_ADD;
                FunctValid = 1'b0;
            end
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD:   ALUControl = ALU_ADD;
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_ctrl;
            default:     ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore control FSM for the multicycle MIPS datapath
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Op, Funct         opcode / funct fields from the instruction register
//   Zero              ALU zero flag, qualifies PCEn in BRANCH
//   IRWrite, PCEn, MemWrite, RegWrite   write enables (all 0 while reset=1)
//   IorD, RegDst, MemtoReg, ALUSrcA     1-bit datapath selects
//   ALUSrcB, PCSrc                      2-bit datapath selects
//   ALUControl                          3-bit ALU operation
module multicycle_control_unit
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl
);

    state_t state, next_state, out_state;
    aluop_t aluop;
    logic   funct_valid;
    logic   pcwrite, branch, irwrite_s, memwrite_s, regwrite_s;

    alu_decoder u_alu_decoder (
        .ALUOp      (aluop),
        .Funct      (Funct),
        .ALUControl (ALUControl),
        .FunctValid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = funct_valid ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything not lw is a store.
            S_MEMADR:   next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // While reset is high the outputs show FETCH values; the enables are
    // masked below so nothing architectural is written.
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        irwrite_s  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PCSRC_ALURESULT;
        aluop      = ALUOP_ADD;
        case (out_state)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
                irwrite_s = 1'b0;
            end
        endcase
    end

    assign IRWrite  = irwrite_s & ~reset;
    assign MemWrite = memwrite_s & ~reset;
    assign RegWrite = regwrite_s & ~reset;
    assign PCEn     = (pcwrite | (branch & Zero)) & ~reset;

endmodule
